uart_rx: RTL and testbench

Serial receive front end of the logic-analyzer command path. It deserializes 8N1 UART frames on `rx_i`, LSB first, and gathers five consecutive bytes into one 40-bit command word. It presents the word on `data_o` with a single-cycle `stb_o` pulse, which feeds the command decoder.

---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver that packs five consecutive bytes into one 40-bit command word.
// Define UART_RX_SYNC_EN to place a two-flop synchronizer in front of the receiver FSM.
module uart_rx #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic        clk_i,
   input  logic        rst_in,
   input  logic        rx_i,
   output logic [39:0] data_o,
   output logic        stb_o
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   logic rx_s;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync_reg;

   always_ff @(posedge clk_i) begin
      if (rst_in) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx_i};
      end
   end

   assign rx_s = sync_reg[1];
`else
   assign rx_s = rx_i;
`endif

   state_t        state_reg, state_next;
   logic [CW-1:0] baud_reg, baud_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic [2:0]    byte_cnt_reg, byte_cnt_next;
   logic [31:0]   stage_reg;
   logic [39:0]   data_reg;
   logic          stb_reg;
   logic          accept;
   logic          word_done;

   always_ff @(posedge clk_i) begin
      if (rst_in) begin
         state_reg    <= IDLE;
         baud_reg     <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         byte_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         baud_reg     <= baud_next;
         bit_reg      <= bit_next;
         shift_reg    <= shift_next;
         byte_cnt_reg <= byte_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      baud_next     = baud_reg;
      bit_next      = bit_reg;
      shift_next    = shift_reg;
      byte_cnt_next = byte_cnt_reg;
      accept        = 1'b0;
      word_done     = 1'b0;

      case (state_reg)
         IDLE: begin
            baud_next = '0;
            if (!rx_s) begin
               state_next = START;
            end
         end

         START: begin
            if (baud_reg == HALF_CNT) begin
               baud_next = '0;
               if (!rx_s) begin
                  state_next = DATA;
                  bit_next   = '0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end

         DATA: begin
            if (baud_reg == FULL_CNT) begin
               baud_next  = '0;
               shift_next = {rx_s, shift_reg[7:1]};
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_reg + 1'b1;
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end

         STOP: begin
            if (baud_reg == FULL_CNT) begin
               baud_next  = '0;
               state_next = IDLE;
               if (rx_s) begin
                  accept = 1'b1;
                  if (byte_cnt_reg == 3'd4) begin
                     byte_cnt_next = '0;
                     word_done     = 1'b1;
                  end else begin
                     byte_cnt_next = byte_cnt_reg + 1'b1;
                  end
               end else begin
                  // framing error: the whole partial word is abandoned
                  byte_cnt_next = '0;
               end
            end else begin
               baud_next = baud_reg + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The first four bytes are staged per lane; the fifth goes straight to the output word.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         always_ff @(posedge clk_i) begin
            if (rst_in) begin
               stage_reg[8*gi +: 8] <= '0;
            end else if (accept && (byte_cnt_reg == 3'(gi))) begin
               stage_reg[8*gi +: 8] <= shift_reg;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_in) begin
         data_reg <= '0;
         stb_reg  <= 1'b0;
      end else begin
         stb_reg <= word_done;
         if (word_done) begin
            data_reg <= {shift_reg, stage_reg};
         end
      end
   end

   assign data_o = data_reg;
   assign stb_o  = stb_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: a byte-level reference model queues expected
// words and strobe cycles, and a negedge monitor checks every strobe and every hold cycle.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif
   localparam int CPB = 20;
   localparam int LAT = 9 * CPB + CPB / 2 + 1 + SYNC_DLY;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1;
   logic        rx_i = 1'b1;
   logic [39:0] data_o;
   logic        stb_o;

   uart_rx #(
      .CLK_FREQ(2_000_000),
      .BAUD(100_000)
   ) dut (
      .clk_i(clk),
      .rst_in(rst_in),
      .rx_i(rx_i),
      .data_o(data_o),
      .stb_o(stb_o)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_q = 1'b1;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_in;
   end

   typedef struct {
      logic [39:0] word;
      int          at;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model_bytes[$];
   int         tests = 0;
   int         fails = 0;
   bit         mon_en = 1'b0;
   logic [39:0] prev_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: collect accepted bytes; five of them form one word, byte n at bits [8n+7:8n].
   task automatic model_accept(input logic [7:0] b, input int start_cyc);
      logic [39:0] w;
      exp_t        e;
      model_bytes.push_back(b);
      if (model_bytes.size() == 5) begin
         w = '0;
         for (int n = 0; n < 5; n++) begin
            w = w + (40'(model_bytes[n]) << (8 * n));
         end
         e.word = w;
         e.at   = start_cyc + 1 + LAT;
         exp_q.push_back(e);
         model_bytes.delete();
      end
   endtask

   task automatic hold(input logic v, input int n);
      rx_i = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      int start_cyc;
      start_cyc = cyc;
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) begin
         hold(b[i], CPB);
      end
      if (stop_ok) begin
         model_accept(b, start_cyc);
         hold(1'b1, CPB);
      end else begin
         model_bytes.delete();
         hold(1'b0, CPB);
         hold(1'b1, 2 * CPB);
      end
   endtask

   task automatic send_glitch(input int n);
      hold(1'b0, n);
      hold(1'b1, 2 * CPB);
   endtask

   task automatic pulse_reset();
      rst_in = 1'b1;
      @(posedge clk);
      #1;
      rst_in = 1'b0;
      model_bytes.delete();
      check("reset_data", 64'(data_o), 64'h0);
      check("reset_stb", 64'(stb_o), 64'h0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (stb_o) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_stb: got data %0h, expected no strobe (cycle %0d)", data_o, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("word_data", 64'(data_o), 64'(e.word));
               check("word_latency", 64'(cyc), 64'(e.at));
            end
         end else begin
            check("data_hold", 64'(data_o), rst_q ? 64'h0 : 64'(prev_data));
         end
         prev_data = data_o;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] w1[5];
      logic [7:0] b;
      int         kind;

      rst_in = 1'b1;
      rx_i   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_in = 1'b0;
      check("reset_data", 64'(data_o), 64'h0);
      check("reset_stb", 64'(stb_o), 64'h0);
      prev_data = data_o;
      mon_en    = 1'b1;
      hold(1'b1, 2 * CPB);

      w1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      foreach (w1[i]) begin
         send_frame(w1[i], 1'b1);
         hold(1'b1, CPB);
      end
      check("word_basic", 64'(data_o), 64'h0504030201);

      w1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      foreach (w1[i]) send_frame(w1[i], 1'b1);
      check("word_b2b_1", 64'(data_o), 64'h5544332211);
      w1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      foreach (w1[i]) send_frame(w1[i], 1'b1);
      check("word_b2b_2", 64'(data_o), 64'hEEDDCCBBAA);
      hold(1'b1, CPB);

      send_glitch(CPB / 2 - 3);
      for (int i = 0; i < 5; i++) send_frame(8'hFF, 1'b1);
      check("word_glitch", 64'(data_o), 64'hFFFFFFFFFF);
      hold(1'b1, CPB);

      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      send_frame(8'h56, 1'b0);
      w1 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      foreach (w1[i]) send_frame(w1[i], 1'b1);
      check("word_framing", 64'(data_o), 64'hA5A4A3A2A1);
      hold(1'b1, CPB);

      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      hold(1'b1, CPB);
      pulse_reset();
      hold(1'b1, CPB);
      w1 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      foreach (w1[i]) send_frame(w1[i], 1'b1);
      check("word_after_reset", 64'(data_o), 64'h5040302010);
      hold(1'b1, CPB);

      for (int it = 0; it < 100; it++) begin
         kind = $urandom_range(0, 19);
         b    = 8'($urandom);
         if (kind == 0) begin
            send_glitch($urandom_range(1, CPB / 2 - 3));
         end else if (kind == 1) begin
            send_frame(b, 1'b0);
         end else if (kind == 2) begin
            pulse_reset();
            hold(1'b1, CPB);
         end else begin
            send_frame(b, 1'b1);
            hold(1'b1, $urandom_range(0, CPB));
         end
      end

      hold(1'b1, 3 * CPB);
      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
